// File: rtl/mover_pkg.sv
// Shared definitions for the player/enemy movers: direction indices,
// coordinate width and the mover FSM state encoding.
package mover_pkg;

  localparam int POS_W = 11;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_BUMP = 2'd2
  } state_t;

endpackage

// File: rtl/step_timer.sv
// Free-running step-rate divider. Emits a one-cycle tick every STEP_DIV
// clocks; the count holds (and tick is masked) while frozen.
module step_timer #(
  parameter int STEP_DIV = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  output logic tick
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(STEP_DIV - 1));
  assign tick   = w_last & ~freeze;

  // Count 0..STEP_DIV-1 and wrap; pause in place while frozen.
  always_ff @(posedge clk) begin
    if (!rst)
      r_cnt <= '0;
    else if (!freeze)
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/player_mover.sv
// Player position controller: arbitrates keyboard direction requests,
// steps the registered x/y at the step_timer rate, and stops with a
// single bump pulse when the chosen direction is blocked or at the edge.
module player_mover
  import mover_pkg::*;
#(
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 100,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 783,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 583,
  parameter int STEP     = 2,
  parameter int STEP_DIV = 400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [0:3]       dir_req,
  input  logic [0:3]       blocked,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic [1:0]       facing,
  output logic             moving,
  output logic             bump
);

  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

  state_t           r_state;
  logic [POS_W-1:0] r_x, r_y;
  logic [1:0]       r_facing;
  logic             r_moving, r_bump;

  logic             w_tick;
  logic             w_up, w_dn, w_lt, w_rt;
  logic             w_valid;
  logic [1:0]       w_dir;
  logic             w_edge;
  logic             w_stop;
  logic [POS_W-1:0] w_nx, w_ny;

  step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .tick   (w_tick)
  );

  // Opposite requests cancel before priority is applied.
  assign w_up = dir_req[0] & ~dir_req[1];
  assign w_dn = dir_req[1] & ~dir_req[0];
  assign w_lt = dir_req[2] & ~dir_req[3];
  assign w_rt = dir_req[3] & ~dir_req[2];

  // Fixed priority up > down > left > right.
  always_comb begin
    w_valid = 1'b1;
    w_dir   = DIR_UP;
    if (w_up)      w_dir = DIR_UP;
    else if (w_dn) w_dir = DIR_DOWN;
    else if (w_lt) w_dir = DIR_LEFT;
    else if (w_rt) w_dir = DIR_RIGHT;
    else           w_valid = 1'b0;
  end

  // Edge test on the pre-step position; done in int so MIN+STEP/MAX-STEP
  // can't underflow the 11-bit coordinate.
  always_comb begin
    w_edge = 1'b0;
    case (w_dir)
      DIR_UP:    w_edge = int'(r_y) < (Y_MIN + STEP);
      DIR_DOWN:  w_edge = int'(r_y) > (Y_MAX - STEP);
      DIR_LEFT:  w_edge = int'(r_x) < (X_MIN + STEP);
      default:   w_edge = int'(r_x) > (X_MAX - STEP);
    endcase
  end

  assign w_stop = blocked[w_dir] | w_edge;

  // Candidate position one step along the arbitrated direction.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    case (w_dir)
      DIR_UP:    w_ny = r_y - STEP_P;
      DIR_DOWN:  w_ny = r_y + STEP_P;
      DIR_LEFT:  w_nx = r_x - STEP_P;
      default:   w_nx = r_x + STEP_P;
    endcase
  end

  // Mover FSM with registered position, facing, moving and bump.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_x      <= POS_W'(X_INIT);
      r_y      <= POS_W'(Y_INIT);
      r_facing <= DIR_DOWN;
      r_moving <= 1'b0;
      r_bump   <= 1'b0;
    end else begin
      r_bump <= 1'b0;
      if (freeze) begin
        r_state  <= ST_IDLE;
        r_moving <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_MOVE: begin
            if (w_tick) begin
              if (!w_valid) begin
                r_state  <= ST_IDLE;
                r_moving <= 1'b0;
              end else if (w_stop) begin
                r_state  <= ST_BUMP;
                r_facing <= w_dir;
                r_bump   <= 1'b1;
                r_moving <= 1'b0;
              end else begin
                r_x      <= w_nx;
                r_y      <= w_ny;
                r_facing <= w_dir;
                r_state  <= ST_MOVE;
                r_moving <= 1'b1;
              end
            end
          end
          // Sit here until the blocked key is released; no re-pulse.
          ST_BUMP: begin
            if (!dir_req[r_facing]) begin
              r_state  <= ST_IDLE;
              r_moving <= 1'b0;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_moving <= 1'b0;
          end
        endcase
      end
    end
  end

  assign xpos   = r_x;
  assign ypos   = r_y;
  assign facing = r_facing;
  assign moving = r_moving;
  assign bump   = r_bump;

endmodule

// File: doc/player_mover.md
Name: player_mover

Overview:
- Downstream consumer of the collision holder (HOLD_TIME-stretched 4-bit blocked flags).
- Converts direction requests from the keyboard decoder into registered player x/y pixel coordinates, stepping at a fixed rate.
- Stops movement in any direction whose held collision flag is set, and flags a one-cycle bump event.
- Feeds the sprite draw stage and the sound/score logic.

Parameters:
- X_INIT, 100, reset x position (pixels)
- Y_INIT, 100, reset y position (pixels)
- X_MIN, 0, lowest legal x
- X_MAX, 783, highest legal x
- Y_MIN, 0, lowest legal y
- Y_MAX, 583, highest legal y
- STEP, 2, pixels moved per step tick
- STEP_DIV, 400000, clock cycles per step tick (minimum 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset; sampled on rising clk; 0 = reset
- freeze  in  1  1 = halt movement (pause/game over)
- dir_req  in  [0:3]  requested directions; bit0 up, bit1 down, bit2 left, bit3 right
- blocked  in  [0:3]  held collision flags from holder; same bit order
- xpos  out  [10:0]  current x, registered
- ypos  out  [10:0]  current y, registered
- facing  out  [1:0]  last accepted direction index (0 up, 1 down, 2 left, 3 right)
- moving  out  1  1 while in MOVE state
- bump  out  1  single-cycle pulse on entry to BUMP

Behaviour:
- Reset (rst=0 at a clk edge) values:
  - xpos=X_INIT, ypos=Y_INIT, facing=1, moving=0, bump=0.
  - Tick counter 0, state IDLE.
  - Reset wins over every other input, including mid-step.
- Tick counter:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick=1 for the single cycle in which the count equals STEP_DIV-1.
  - While freeze=1, the counter holds and tick is suppressed.
- Arbitration (combinational on dir_req):
  - Opposite pairs cancel: up+down gives no vertical request; left+right gives no horizontal request.
  - Among the remaining requests, priority is up > down > left > right.
  - Result: a valid flag plus a 2-bit direction d.
- Boundary check:
  - edge(d) is true when the step would leave the range:
    - up: ypos < Y_MIN+STEP
    - down: ypos > Y_MAX-STEP
    - left: xpos < X_MIN+STEP
    - right: xpos > X_MAX-STEP
  - Positions never leave [MIN,MAX]. No wrap-around.
- FSM states: IDLE, MOVE, BUMP. Transitions are evaluated only on tick, except the freeze and BUMP-release rules below.
  - IDLE, on tick with a valid request:
    - If blocked[d] or edge(d): go to BUMP, facing=d, pulse bump.
    - Otherwise: apply a STEP in d, facing=d, go to MOVE.
  - MOVE, on tick:
    - No valid request: go to IDLE.
    - Valid request, blocked[d] or edge(d): go to BUMP, facing=d, pulse bump, position unchanged.
    - Otherwise: step in d, facing=d. A direction change is allowed without passing through IDLE.
  - BUMP:
    - When dir_req[facing]=0, go to IDLE on the next clk, not tick-gated.
    - Holding the blocked direction never re-pulses bump.
    - A request for a different direction is ignored until the blocked one is released.
  - Any state with freeze=1: go to IDLE on the next clk. Position holds; no bump.
- Latency and outputs:
  - Position, facing and bump update on the clk edge that samples tick=1, so they are visible one cycle after the tick cycle.
  - moving = (state==MOVE), registered.
- Simultaneous events: if blocked[d] rises in the same cycle as the tick, the block wins (no step taken).
- Arithmetic: 11-bit unsigned; edge comparisons use the pre-step value.

Decomposition:
- Package mover_pkg holds:
  - DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3
  - POS_W=11
  - FSM state encoding (IDLE=2'd0, MOVE=2'd1, BUMP=2'd2)
- One sub-module, step_timer: parameter STEP_DIV; ports clk, rst, freeze, tick. Reused by the enemy mover.
- Arbitration and FSM stay in player_mover.

Test Plan:
- Bench parameters: STEP_DIV=4, STEP=2, X_INIT=Y_INIT=100, mins 0, maxes 200.
1. Reset: hold rst=0 for 3 clks with dir_req=4'b1000 -> xpos=100, ypos=100, facing=1, moving=0, bump=0; no step taken.
2. dir_req=4'b0001 (right) for 3 ticks, blocked=0 -> xpos 102, 104, 106, each 1 clk after its tick; moving=1; facing=3.
3. Moving right, blocked=4'b0001 set before the next tick -> xpos stays at its value, bump high exactly 1 clk, state BUMP; xpos holds over 5 further ticks; dropping dir_req gives moving=0 the next clk.
4. dir_req=4'b1100 (up+down) -> no movement. dir_req=4'b1010 (up+left) -> up wins: ypos 100 to 98.
5. Start y=1 (Y_INIT=1), request up -> ypos stays 1, bump pulses once, never 0 or wrapped to 2047.
6. freeze=1 mid-MOVE -> counter halts, moving=0 next clk, position frozen; freeze=0 resumes stepping after STEP_DIV cycles.
